// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Round-robin arbiter and burst sequencer for the shared multiplexed AddrData
// bus in front of the memory controller. One requester is granted at a time
// for one address cycle, BURST_LEN data beats and TURNAROUND idle cycles.
//
// Ports
//   clk        clock shared with memory controller and memory
//   resetH     synchronous active-high reset
//   req        per-requester bus request (level, held until granted)
//   rw_req     per-requester direction, 1 = read, 0 = write
//   gnt        one-hot grant; holder owns AddrData
//   AddrValid  high in the address cycle only
//   rw         burst direction, valid from address cycle to last data beat
//   beat       data beat index, 0 outside the data phase
//   busy       high from address cycle through end of turnaround
//   xfer_done  one-cycle pulse on the last data beat
module mem_bus_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int BURST_LEN  = 4,
   parameter int TURNAROUND = 1
) (
   input  logic               clk,
   input  logic               resetH,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] rw_req,
   output logic [NUM_REQ-1:0] gnt,
   output logic               AddrValid,
   output logic               rw,
   output logic [2:0]         beat,
   output logic               busy,
   output logic               xfer_done
);

   localparam int PW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
   localparam logic [PW-1:0] LAST_IDX  = PW'(NUM_REQ - 1);
   localparam logic [2:0]    BEAT_LAST = 3'(BURST_LEN - 1);
   localparam logic [1:0]    TURN_LAST = (TURNAROUND > 0) ? 2'(TURNAROUND - 1) : 2'd0;

   typedef enum logic [1:0] {IDLE, ADDR, DATA, TURN} state_t;

   state_t              state, state_d;
   logic [1:0]          tcnt, tcnt_d;
   logic [PW-1:0]       ptr, ptr_d, win, idx;
   logic                arb_pt, go;

   logic [NUM_REQ-1:0]  gnt_d;
   logic                av_d, rw_d, busy_d, done_d;
   logic [2:0]          beat_d;

   // Round-robin pick: scanning from the far end of the search order back to
   // ptr leaves the first set bit (starting at ptr) as the final assignment.
   always_comb begin
      win = '0;
      idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = PW'((int'(ptr) + i) % NUM_REQ);
         if (req[idx]) win = idx;
      end
   end

   // Arbitration happens in IDLE, in the final TURN cycle, or on the last
   // data beat when there is no turnaround gap at all.
   always_comb begin
      arb_pt = (state == IDLE) ||
               (state == TURN && tcnt == TURN_LAST) ||
               (state == DATA && beat == BEAT_LAST && TURNAROUND == 0);
      go = arb_pt && (|req);
   end

   // Next-state logic
   always_comb begin
      state_d = state;
      tcnt_d  = tcnt;
      ptr_d   = ptr;
      case (state)
         IDLE: ;
         ADDR: state_d = DATA;
         DATA: begin
            if (beat == BEAT_LAST) begin
               state_d = (TURNAROUND == 0) ? IDLE : TURN;
               tcnt_d  = 2'd0;
            end
         end
         TURN: begin
            if (tcnt == TURN_LAST) state_d = IDLE;
            else                   tcnt_d  = tcnt + 2'd1;
         end
         default: state_d = IDLE;
      endcase
      if (go) begin
         state_d = ADDR;
         ptr_d   = (win == LAST_IDX) ? '0 : win + PW'(1);
      end
   end

   // Output logic: values the outputs take in the next state, so that every
   // output comes straight from a flop.
   always_comb begin
      gnt_d  = '0;
      av_d   = 1'b0;
      rw_d   = 1'b0;
      beat_d = 3'd0;
      busy_d = (state_d != IDLE);
      done_d = 1'b0;
      case (state_d)
         ADDR: begin
            gnt_d = NUM_REQ'(1) << win;
            av_d  = 1'b1;
            rw_d  = rw_req[win];
         end
         DATA: begin
            gnt_d  = gnt;
            rw_d   = rw;
            beat_d = (state == DATA) ? beat + 3'd1 : 3'd0;
            done_d = (beat_d == BEAT_LAST);
         end
         default: ;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (resetH) begin
         state     <= IDLE;
         tcnt      <= 2'd0;
         ptr       <= '0;
         gnt       <= '0;
         AddrValid <= 1'b0;
         rw        <= 1'b0;
         beat      <= 3'd0;
         busy      <= 1'b0;
         xfer_done <= 1'b0;
      end else begin
         state     <= state_d;
         tcnt      <= tcnt_d;
         ptr       <= ptr_d;
         gnt       <= gnt_d;
         AddrValid <= av_d;
         rw        <= rw_d;
         beat      <= beat_d;
         busy      <= busy_d;
         xfer_done <= done_d;
      end
   end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Round-robin arbiter and transaction sequencer for the shared multiplexed AddrData bus that feeds the memory controller. Several CPU-side requesters compete for the bus. The block grants one at a time for one full burst: address cycle, BURST_LEN data beats, then a tristate turnaround gap. It generates the AddrValid and rw strobes seen by the memory controller, so requesters only drive AddrData while granted.

## Interface
- NUM_REQ, 2: number of requesters (2..8).
- BURST_LEN, 4: data beats per transaction (1..8).
- TURNAROUND, 1: idle bus cycles after each burst (0..3).
- clk  input  1  clock shared with the memory controller and memory.
- resetH  input  1  reset; synchronous and active-high.
- req  input  NUM_REQ  per-requester bus request; level, held until granted.
- rw_req  input  NUM_REQ  per-requester direction; 1 = read, 0 = write; sampled only in the ADDR cycle.
- gnt  output  NUM_REQ  one-hot grant; requester i owns AddrData while gnt[i]=1.
- AddrValid  output  1  high only in the ADDR cycle; to the memory controller.
- rw  output  1  direction to the memory controller; valid from ADDR through the last DATA beat.
- beat  output  3  current data beat index, 0..BURST_LEN-1; 0 outside DATA.
- busy  output  1  high from ADDR through the end of TURN.
- xfer_done  output  1  one-cycle pulse on the last DATA beat.

## Operation
- States: IDLE, ADDR, DATA, TURN. All outputs are registered.
- IDLE: if any req bit is set, pick a winner by round-robin and go to ADDR with gnt set to the winner. Otherwise stay in IDLE.
- ADDR, one cycle:
  - AddrValid=1.
  - rw is latched from rw_req[winner]. The winner drives the address on AddrData this cycle.
  - Next state is DATA with beat=0.
- DATA, BURST_LEN cycles:
  - beat increments by 1 each cycle.
  - A write winner drives data. On a read, the memory controller drives data.
  - On beat==BURST_LEN-1: xfer_done=1, and the next state is TURN. If TURNAROUND=0, apply the arbitration point below instead.
- TURN, TURNAROUND cycles:
  - gnt=0, AddrValid=0, rw=0, busy=1.
  - In the final TURN cycle, arbitrate. A pending req goes straight to ADDR (no IDLE cycle). Otherwise go to IDLE.
- Round-robin:
  - The priority pointer p resets to 0.
  - Search order is p, p+1, … mod NUM_REQ. The first set req bit wins.
  - After granting i, p becomes (i+1) mod NUM_REQ.
- gnt stays constant from ADDR through the last DATA beat. Deasserting req after the grant does not abort; the burst always completes.
- Reasserting req by the same requester is legal. If other requesters are waiting, it waits behind them.

## Timing
- Reset, sampled on a clk edge: the next cycle has state=IDLE, gnt=0, AddrValid=0, rw=0, beat=0, busy=0, xfer_done=0, p=0.
- Reset mid-burst behaves the same. The burst is abandoned with no xfer_done.
- Latency from req rising in IDLE to ADDR is 1 cycle: req sampled at edge N, gnt and AddrValid high after edge N.
- Transaction length is 1 + BURST_LEN + TURNAROUND cycles.
- Back-to-back bursts have no idle gap beyond TURNAROUND. Peak bus occupancy is (1+BURST_LEN)/(1+BURST_LEN+TURNAROUND).
- Simultaneous requests are resolved only by p. Requests arriving mid-burst wait until the next arbitration point.
- beat is a 3-bit counter. It never wraps past BURST_LEN-1 and clears to 0 on leaving DATA.
- Outside ADDR..last DATA, gnt must be all-zero, so AddrData is undriven by requesters (release/turnaround).

## Test plan
- Reset check: assert resetH for 2 cycles with req=2'b11 → all outputs 0 and state IDLE. Release → ADDR with gnt=2'b01 on the next cycle.
- Single write from req0 (rw_req=0), defaults:
  - Expected sequence: AddrValid=1 for 1 cycle with rw=0, then beat 0,1,2,3 with xfer_done on beat 3.
  - Then 1 TURN cycle with gnt=0, then IDLE.
  - busy is high for 6 cycles.
- Contention: req=2'b11 held continuously → grants alternate 01,10,01,10. ADDR starts every 6 cycles with no IDLE between bursts.
- Read from req1 (rw_req[1]=1) while req0 rises mid-DATA → req1's burst completes untouched with rw=1 throughout. req0 gets ADDR right after TURN.
- Mid-burst reset at beat=2 → next cycle gnt=0, AddrValid=0, no xfer_done. With req=2'b10 pending, the pointer restarts at 0 and req1 is granted one cycle after reset release.
- TURNAROUND=0, BURST_LEN=1, req0 held → ADDR, DATA, ADDR, DATA…; xfer_done every 2 cycles; gnt never drops.
